// File: rtl/uart_deframer_pkg.sv
// Shared types and constants for the UART receive deframer.
// Optional inter-byte timeout is enabled by defining UART_DEFRAMER_TIMEOUT_EN.
package uart_deframer_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'b000;
    localparam logic [2:0] ERR_LEN     = 3'b001;
    localparam logic [2:0] ERR_LINE    = 3'b010;
    localparam logic [2:0] ERR_CSUM    = 3'b011;
    localparam logic [2:0] ERR_TIMEOUT = 3'b100;

    // RXRDY from the UART core is registered, so it lags a read by two cycles.
    localparam int HOLDOFF_CYCLES = 2;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_deframer_buf.sv
// Payload store for the deframer: one write port, one registered read port, no reset.
module uart_deframer_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_reg [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        rd_data <= mem_reg[rd_addr];
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// Pulls bytes from a UART core, checks SOF/length/checksum frames and streams the payload.
// Define UART_DEFRAMER_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES.
module uart_rx_deframer
    import uart_deframer_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = 8'h7E,
    parameter int         MAX_LEN        = 32,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXRDY,
    input  logic [7:0] DATA_OUT,
    input  logic       PARITY_ERR,
    input  logic       FRAMING_ERR,
    output logic       CSN,
    output logic       OEN,
    output logic       M_VALID,
    input  logic       M_READY,
    output logic [7:0] M_DATA,
    output logic       M_LAST,
    output logic       FRAME_OK,
    output logic       FRAME_ERR,
    output logic [2:0] ERR_CODE
);

    localparam int AW = addr_width(MAX_LEN);

    state_t        state_reg;
    logic          strobe_reg;
    logic [1:0]    holdoff_reg;
    logic [7:0]    len_reg;
    logic [7:0]    idx_reg;
    logic [7:0]    sum_reg;
    logic [7:0]    out_idx_reg;
    logic          m_valid_reg;
    logic          m_last_reg;
    logic          frame_ok_reg;
    logic          frame_err_reg;
    logic [2:0]    err_code_reg;

    logic          rd_go;
    logic          line_ok;
    logic          drain_fire;
    logic          buf_we;
    logic [AW-1:0] rd_addr_next;
    logic [7:0]    buf_rd_data;

`ifdef UART_DEFRAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_reg;
`endif

    always_comb begin
        rd_go = 1'b0;
        if (state_reg != ST_DRAIN) begin
            rd_go = RXRDY && (holdoff_reg == 2'd0) && !strobe_reg;
        end
        line_ok    = !(PARITY_ERR || FRAMING_ERR);
        drain_fire = (state_reg == ST_DRAIN) && m_valid_reg && M_READY;
        buf_we     = strobe_reg && (state_reg == ST_PAYLOAD) && line_ok;
        // Look one byte ahead on a handshake so the next byte is ready with no bubble.
        rd_addr_next = (drain_fire && !m_last_reg) ? out_idx_reg[AW-1:0] + AW'(1)
                                                   : out_idx_reg[AW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_HUNT;
            strobe_reg    <= 1'b0;
            holdoff_reg   <= 2'd0;
            len_reg       <= 8'h00;
            idx_reg       <= 8'h00;
            sum_reg       <= 8'h00;
            out_idx_reg   <= 8'h00;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
`ifdef UART_DEFRAMER_TIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
        end else begin
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
            strobe_reg    <= rd_go;

            if (strobe_reg) begin
                holdoff_reg <= 2'(HOLDOFF_CYCLES);
            end else if (holdoff_reg != 2'd0) begin
                holdoff_reg <= holdoff_reg - 2'd1;
            end

`ifdef UART_DEFRAMER_TIMEOUT_EN
            if (strobe_reg || state_reg == ST_HUNT || state_reg == ST_DRAIN) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_reg    <= '0;
                frame_err_reg <= 1'b1;
                err_code_reg  <= ERR_TIMEOUT;
                state_reg     <= ST_HUNT;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
`endif

            case (state_reg)
                ST_HUNT: begin
                    if (strobe_reg && line_ok && DATA_OUT == SOF_BYTE) begin
                        state_reg <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (strobe_reg) begin
                        if (!line_ok) begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LINE;
                            state_reg     <= ST_HUNT;
                        end else if (DATA_OUT != 8'h00 && DATA_OUT <= 8'(MAX_LEN)) begin
                            len_reg   <= DATA_OUT;
                            sum_reg   <= DATA_OUT;
                            idx_reg   <= 8'h00;
                            state_reg <= ST_PAYLOAD;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LEN;
                            state_reg     <= ST_HUNT;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (strobe_reg) begin
                        if (!line_ok) begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LINE;
                            state_reg     <= ST_HUNT;
                        end else begin
                            sum_reg <= sum_reg + DATA_OUT;
                            idx_reg <= idx_reg + 8'd1;
                            if (idx_reg == len_reg - 8'd1) begin
                                state_reg <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (strobe_reg) begin
                        if (!line_ok) begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LINE;
                            state_reg     <= ST_HUNT;
                        end else if (DATA_OUT == sum_reg) begin
                            frame_ok_reg <= 1'b1;
                            out_idx_reg  <= 8'h00;
                            state_reg    <= ST_DRAIN;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_CSUM;
                            state_reg     <= ST_HUNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!m_valid_reg) begin
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= (len_reg == 8'd1);
                    end else if (M_READY) begin
                        if (m_last_reg) begin
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            state_reg   <= ST_HUNT;
                        end else begin
                            out_idx_reg <= out_idx_reg + 8'd1;
                            m_last_reg  <= (out_idx_reg + 8'd2 == len_reg);
                        end
                    end
                end
                default: state_reg <= ST_HUNT;
            endcase
        end
    end

    uart_deframer_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .CLK     (CLK),
        .wr_en   (buf_we),
        .wr_addr (idx_reg[AW-1:0]),
        .wr_data (DATA_OUT),
        .rd_addr (rd_addr_next),
        .rd_data (buf_rd_data)
    );

    assign CSN       = ~strobe_reg;
    assign OEN       = ~strobe_reg;
    assign M_VALID   = m_valid_reg;
    assign M_LAST    = m_last_reg;
    assign M_DATA    = m_valid_reg ? buf_rd_data : 8'h00;
    assign FRAME_OK  = frame_ok_reg;
    assign FRAME_ERR = frame_err_reg;
    assign ERR_CODE  = err_code_reg;

endmodule

// File: doc/uart_rx_deframer.md
UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter SOF_BYTE, default 8'h7E, start-of-frame marker.
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum payload bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, inter-byte timeout in CLK cycles (used only with the macro in REQ-027).
REQ-004 SHALL have the following ports.
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset.
- RXRDY  in  1  UART core has a received byte.
- DATA_OUT  in  8  UART core receive data, combinational, valid while CSN/OEN are low.
- PARITY_ERR  in  1  UART parity error flag for the current byte.
- FRAMING_ERR  in  1  UART framing error flag for the current byte.
- CSN  out  1  UART chip select, active low.
- OEN  out  1  UART read enable, active low.
- M_VALID  out  1  payload byte valid.
- M_READY  in  1  payload sink ready.
- M_DATA  out  8  payload byte.
- M_LAST  out  1  final payload byte of the frame.
- FRAME_OK  out  1  one-cycle pulse when a frame passes the checksum.
- FRAME_ERR  out  1  one-cycle pulse when a frame is discarded.
- ERR_CODE  out  3  cause of discard, valid with FRAME_ERR.

Function
REQ-005 SHALL take byte reads from the UART only in HUNT, LEN, PAYLOAD and CSUM states, and only when RXRDY=1 and the holdoff counter is 0.
REQ-006 SHALL perform a byte read by driving CSN=0 and OEN=0 for exactly one cycle; in that same cycle it SHALL sample DATA_OUT, PARITY_ERR and FRAMING_ERR.
REQ-007 SHALL ignore RXRDY for the 2 cycles after a read strobe (holdoff), because RXRDY is registered.
REQ-008 SHALL hold CSN=1 and OEN=1 at all other times.
REQ-009 SHALL use states HUNT, LEN, PAYLOAD, CSUM, DRAIN.
REQ-010 HUNT: a byte equal to SOF_BYTE -> LEN; any other byte is dropped silently.
REQ-011 LEN: a byte L with 1<=L<=MAX_LEN is stored, the running sum is set to L, the state goes to PAYLOAD (or CSUM if L=0 is excluded, which it is); otherwise FRAME_ERR fires with ERR_CODE=3'b001 and the state goes to HUNT.
REQ-012 PAYLOAD: each byte is written to buffer address idx and added to the running sum (mod 256); after the L-th byte the state goes to CSUM.
REQ-013 CSUM: if the byte equals the running sum, FRAME_OK fires and the state goes to DRAIN; else FRAME_ERR fires with ERR_CODE=3'b011 and the state goes to HUNT.
REQ-014 In any of LEN, PAYLOAD or CSUM, a byte read with PARITY_ERR=1 or FRAMING_ERR=1 SHALL give FRAME_ERR with ERR_CODE=3'b010 and a return to HUNT; such bytes in HUNT are dropped with no error.
REQ-015 DRAIN: the module SHALL present buffer bytes 0..L-1 in order on M_DATA with M_VALID=1.
REQ-016 In DRAIN, a byte advances only when M_VALID=1 and M_READY=1 in the same cycle.
REQ-017 In DRAIN, M_LAST=1 only with byte L-1; the handshake on that byte returns the state to HUNT.
REQ-018 M_DATA/M_VALID/M_LAST SHALL stay stable while M_VALID=1 and M_READY=0.
REQ-019 In DRAIN the module SHALL NOT read the UART; bytes wait in the UART core.
REQ-020 The first M_VALID SHALL assert the cycle after FRAME_OK, so FRAME_OK-to-first-byte latency is 1 cycle.
REQ-021 Only one of FRAME_OK or FRAME_ERR SHALL pulse per frame; ERR_CODE SHALL be 3'b000 when FRAME_ERR=0.
REQ-022 A byte equal to SOF_BYTE inside LEN, PAYLOAD or CSUM SHALL be treated as data; there is no resync.

Reset
REQ-023 On RESET=1 at a CLK edge: state=HUNT, CSN=1, OEN=1, M_VALID=0, M_LAST=0, M_DATA=8'h00, FRAME_OK=0, FRAME_ERR=0, ERR_CODE=0, holdoff=0, all counters and the sum cleared.
REQ-024 Reset mid-frame or mid-drain SHALL discard the frame with no FRAME_ERR pulse.
REQ-025 Buffer contents SHALL NOT require reset.
REQ-026 Reset asserted during a read strobe SHALL force CSN=1 and OEN=1 on the next cycle.

Configuration
REQ-027 With UART_DEFRAMER_TIMEOUT_EN defined, a counter SHALL clear on every read and count in LEN, PAYLOAD and CSUM; reaching TIMEOUT_CYCLES SHALL give FRAME_ERR with ERR_CODE=3'b100 and a return to HUNT.
REQ-028 Without UART_DEFRAMER_TIMEOUT_EN, the counter SHALL be absent, frames SHALL wait indefinitely, and ERR_CODE=3'b100 SHALL never occur.

Structure
REQ-029 A shared package uart_deframer_pkg SHALL hold the state enum, the ERR_CODE constants (NONE, LEN, LINE, CSUM, TIMEOUT) and the holdoff constant (2).
REQ-030 The payload store SHALL be a sub-module uart_deframer_buf: MAX_LEN x 8 with 1 write port and 1 read port, registered read, no reset.
REQ-031 The read-port address SHALL be prefetched so that REQ-020 is met.

Verification
REQ-032 Bench scenario, valid frame: 7E 03 11 22 33 69 with M_READY=1 -> FRAME_OK once, then M_DATA 11,22,33 on consecutive cycles with M_LAST on 33.
REQ-033 Bench scenario, bad checksum: 7E 02 AA 55 00 -> FRAME_ERR with ERR_CODE=3, no M_VALID; a following 7E 01 05 06 -> FRAME_OK and M_DATA=05 with M_LAST=1.
REQ-034 Bench scenario, length 0 and length 33 (MAX_LEN=32) -> FRAME_ERR with ERR_CODE=1 each, and the next byte is hunted for SOF.
REQ-035 Bench scenario, PARITY_ERR=1 on the 2nd payload byte of 7E 04 ... -> FRAME_ERR with ERR_CODE=2; garbage 00 FF before SOF -> no error.
REQ-036 Bench scenario, backpressure: M_READY toggling 0/1 during a 4-byte drain -> no data loss or duplication; CSN stays 1 throughout DRAIN while RXRDY=1.
REQ-037 Bench scenario, with the macro and TIMEOUT_CYCLES=100: stall after 7E 02 AA -> FRAME_ERR with ERR_CODE=4 at the 100th idle cycle; RESET mid-payload -> HUNT with no error pulse.
